// File: rtl/fnd_scan_if.sv
// Host/decoder-side signal bundle for the FND scan controller.
// slave = controller side, master = host/decoder/testbench side.
interface fnd_scan_if #(
  parameter int NUM_DIG = 4
);
  logic                 scan_en;
  logic                 data_wr;
  logic [4*NUM_DIG-1:0] data_in;
  logic [NUM_DIG-1:0]   dig_blank;
  logic                 seg7_en;
  logic                 seg7_off;
  logic [3:0]           seg7_cnt;
  logic [NUM_DIG-1:0]   dig_sel;
  logic                 frame_start;

  modport slave (
    input  scan_en, data_wr, data_in, dig_blank,
    output seg7_en, seg7_off, seg7_cnt, dig_sel, frame_start
  );

  modport master (
    output scan_en, data_wr, data_in, dig_blank,
    input  seg7_en, seg7_off, seg7_cnt, dig_sel, frame_start
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for an NUM_DIG-digit 7-segment display.
// Define FND_LZB_EN to enable leading-zero blanking of digits above digit 0.
module fnd_scan_ctrl #(
  parameter int NUM_DIG   = 4,
  parameter int SCAN_DIV  = 48000,
  parameter int BLANK_CYC = 16
) (
  input  logic      clk,
  input  logic      rstn,
  fnd_scan_if.slave bus
);
  // state | meaning
  // BLANK | tc <  BLANK_CYC, all digits deselected
  // LOAD  | tc == BLANK_CYC, one-cycle load strobe to the decoder
  // SHOW  | tc >  BLANK_CYC, current digit selected
  typedef enum logic [1:0] {ST_BLANK, ST_LOAD, ST_SHOW} state_t;

  localparam int TCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = $clog2(NUM_DIG);
  localparam int DW  = 4 * NUM_DIG;
  localparam logic [TCW-1:0] LAST_TC  = TCW'(SCAN_DIV - 1);
  localparam logic [TCW-1:0] BLANK_TC = TCW'(BLANK_CYC);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DIG - 1);
  localparam state_t SLOT_ST = (BLANK_CYC == 0) ? ST_LOAD : ST_BLANK;

  state_t             state_q, state_d;
  logic [TCW-1:0]     tc_q, tc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               run_q, run_d;
  logic [DW-1:0]      shd_data_q, shd_data_d;
  logic [NUM_DIG-1:0] shd_blank_q, shd_blank_d;
  logic [DW-1:0]      act_data_q, act_data_d;
  logic [NUM_DIG-1:0] act_blank_q, act_blank_d;
  logic               seg7_en_q, seg7_en_d;
  logic               seg7_off_q, seg7_off_d;
  logic [3:0]         seg7_cnt_q, seg7_cnt_d;
  logic [NUM_DIG-1:0] dig_sel_q, dig_sel_d;
  logic               frame_start_q, frame_start_d;
  logic [NUM_DIG-1:0] lzb_mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BLANK;
      tc_q    <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
    end
  end

  // A fresh start (reset release or scan_en rising) opens digit 0's slot at tc==0.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    idx_d   = idx_q;
    run_d   = run_q;
    if (!bus.scan_en) begin
      state_d = ST_BLANK;
      tc_d    = '0;
      idx_d   = '0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      state_d = SLOT_ST;
      tc_d    = '0;
      idx_d   = '0;
      run_d   = 1'b1;
    end else begin
      if (tc_q == LAST_TC) begin
        tc_d  = '0;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end else begin
        tc_d = tc_q + TCW'(1);
      end
      case (state_q)
        ST_BLANK: if (tc_d == BLANK_TC) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_SHOW;
        ST_SHOW:  if (tc_q == LAST_TC) state_d = SLOT_ST;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

  // Shadow takes host writes; active follows shadow at the end of the
  // frame_start cycle, so a write in that very cycle passes straight through.
  always_comb begin
    shd_data_d  = bus.data_wr ? bus.data_in   : shd_data_q;
    shd_blank_d = bus.data_wr ? bus.dig_blank : shd_blank_q;
    act_data_d  = frame_start_q ? shd_data_d  : act_data_q;
    act_blank_d = frame_start_q ? shd_blank_d : act_blank_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shd_data_q  <= '0;
      shd_blank_q <= '0;
      act_data_q  <= '0;
      act_blank_q <= '0;
    end else begin
      shd_data_q  <= shd_data_d;
      shd_blank_q <= shd_blank_d;
      act_data_q  <= act_data_d;
      act_blank_q <= act_blank_d;
    end
  end

`ifdef FND_LZB_EN
  // Digit k blanks when it and every more significant nibble are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lzb_mask   = '0;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      upper_zero  = upper_zero & (act_data_d[4*k +: 4] == 4'h0);
      lzb_mask[k] = upper_zero;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin
    seg7_en_d     = (state_d == ST_LOAD);
    seg7_cnt_d    = seg7_cnt_q;
    seg7_off_d    = seg7_off_q;
    if (seg7_en_d) begin
      seg7_cnt_d = act_data_d[{idx_d, 2'b00} +: 4];
      seg7_off_d = act_blank_d[idx_d] | lzb_mask[idx_d];
    end
    dig_sel_d = '1;
    if (state_d == ST_SHOW) dig_sel_d[idx_d] = 1'b0;
    frame_start_d = bus.scan_en && (tc_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg7_en_q     <= 1'b0;
      seg7_off_q    <= 1'b1;
      seg7_cnt_q    <= 4'h0;
      dig_sel_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      seg7_en_q     <= seg7_en_d;
      seg7_off_q    <= seg7_off_d;
      seg7_cnt_q    <= seg7_cnt_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg7_en     = seg7_en_q;
  assign bus.seg7_off    = seg7_off_q;
  assign bus.seg7_cnt    = seg7_cnt_q;
  assign bus.dig_sel     = dig_sel_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a time-based reference model predicts
// strobes and per-cycle outputs; a negedge monitor compares them.
module tb_fnd_scan_ctrl;
  localparam int NUM_DIG   = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int DW        = 4 * NUM_DIG;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_if #(.NUM_DIG(NUM_DIG)) bus ();

  fnd_scan_ctrl #(
    .NUM_DIG  (NUM_DIG),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] cnt;
    logic       off;
    int         dig;
  } strobe_t;

  strobe_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit                 m_run;
  int                 m_n;
  bit                 prev_fs;
  logic [DW-1:0]      sh_d, ac_d;
  logic [NUM_DIG-1:0] sh_b, ac_b;
  logic               e_fs, e_en, e_off;
  logic [3:0]         e_cnt;
  logic [NUM_DIG-1:0] e_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // Model: position in the scan is derived from elapsed cycles since enable.
  task automatic model_step();
    int pos, dig;
    strobe_t s;
    if (!rstn) begin
      m_run = 0; m_n = 0; prev_fs = 0;
      sh_d = '0; sh_b = '0; ac_d = '0; ac_b = '0;
      e_fs = 0; e_en = 0; e_sel = '1; e_cnt = 4'h0; e_off = 1'b1;
      sbq.delete();
      return;
    end
    if (bus.data_wr) begin
      sh_d = bus.data_in;
      sh_b = bus.dig_blank;
    end
    if (prev_fs) begin
      ac_d = sh_d;
      ac_b = sh_b;
    end
    if (!bus.scan_en) m_run = 0;
    else if (!m_run) begin m_run = 1; m_n = 0; end
    else m_n++;
    pos = m_n % SCAN_DIV;
    dig = (m_n / SCAN_DIV) % NUM_DIG;
    e_fs  = m_run && pos == 0 && dig == 0;
    e_en  = m_run && pos == BLANK_CYC;
    e_sel = '1;
    if (m_run && pos > BLANK_CYC) e_sel[dig] = 1'b0;
    if (e_en) begin
      e_cnt = 4'((ac_d >> (4 * dig)) & 16'hF);
      e_off = ac_b[dig];
`ifdef FND_LZB_EN
      if (dig > 0 && (ac_d >> (4 * dig)) == '0) e_off = 1'b1;
`endif
      s.cnt = e_cnt; s.off = e_off; s.dig = dig;
      sbq.push_back(s);
    end
    prev_fs = e_fs;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: per-cycle checks plus strobe scoreboard.
  initial forever begin
    strobe_t s;
    @(negedge clk);
    if (rstn) begin
      chk("dig_sel", 32'(bus.dig_sel), 32'(e_sel));
      chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
      chk("seg7_en", 32'(bus.seg7_en), 32'(e_en));
      if (bus.seg7_en) begin
        if (sbq.size() == 0) timeout_fail("strobe_unexpected");
        else begin
          s = sbq.pop_front();
          chk($sformatf("strobe_cnt_d%0d", s.dig), 32'(bus.seg7_cnt), 32'(s.cnt));
          chk($sformatf("strobe_off_d%0d", s.dig), 32'(bus.seg7_off), 32'(s.off));
        end
      end else begin
        chk("hold_cnt", 32'(bus.seg7_cnt), 32'(e_cnt));
        chk("hold_off", 32'(bus.seg7_off), 32'(e_off));
      end
    end
  end

  task automatic write_data(input logic [DW-1:0] d, input logic [NUM_DIG-1:0] b);
    @(posedge clk); #1;
    bus.data_wr = 1'b1; bus.data_in = d; bus.dig_blank = b;
    @(posedge clk); #1;
    bus.data_wr = 1'b0;
  endtask

  task automatic wait_sel(input logic [NUM_DIG-1:0] target, input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dig_sel == target) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_fs(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.frame_start) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_en(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.seg7_en) return;
    end
    timeout_fail(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg7_en"}, 32'(bus.seg7_en), 32'd0);
    chk({tag, "_seg7_off"}, 32'(bus.seg7_off), 32'd1);
    chk({tag, "_seg7_cnt"}, 32'(bus.seg7_cnt), 32'd0);
    chk({tag, "_dig_sel"}, 32'(bus.dig_sel), 32'hF);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
  endtask

  initial begin
    bus.scan_en = 1'b0; bus.data_wr = 1'b0; bus.data_in = '0; bus.dig_blank = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rstn = 1'b1;

    // basic scan of 1234
    write_data(16'h1234, 4'b0000);
    bus.scan_en = 1'b1;
    repeat (80) @(posedge clk);

    // double buffering: write mid digit 2, then write on a frame_start cycle
    wait_sel(4'b1011, "wait_digit2");
    #1 bus.data_wr = 1'b1; bus.data_in = 16'hABCD;
    @(posedge clk); #1 bus.data_wr = 1'b0;
    repeat (70) @(posedge clk);
    wait_fs("wait_frame_start");
    bus.data_wr = 1'b1; bus.data_in = 16'h5678;
    @(posedge clk); #1 bus.data_wr = 1'b0;
    repeat (40) @(posedge clk);

    // blank mask on digit 2
    write_data(16'h1234, 4'b0100);
    repeat (70) @(posedge clk);

    // scan_en pause during digit 1 SHOW
    wait_sel(4'b1101, "wait_digit1");
    @(posedge clk); #1 bus.scan_en = 1'b0;
    repeat (20) @(posedge clk);
    #1 bus.scan_en = 1'b1;
    repeat (40) @(posedge clk);

    // leading-zero patterns
    write_data(16'h0050, 4'b0000);
    repeat (70) @(posedge clk);
    write_data(16'h0000, 4'b0000);
    repeat (70) @(posedge clk);

    // random writes and enable drops
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.data_wr   = ($urandom_range(0, 11) == 0);
      bus.data_in   = DW'($urandom);
      bus.dig_blank = NUM_DIG'($urandom);
      if ($urandom_range(0, 59) == 0) bus.scan_en = ~bus.scan_en;
    end
    @(posedge clk); #1;
    bus.data_wr = 1'b0; bus.scan_en = 1'b1;
    repeat (40) @(posedge clk);

    // asynchronous reset in a LOAD cycle
    wait_en("wait_load");
    #1 rstn = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk); #1 rstn = 1'b1;
    wait_en("wait_first_strobe");
    chk("post_rst_dig0_cnt", 32'(bus.seg7_cnt), 32'd0);
    repeat (40) @(posedge clk);

    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
